// File: rtl/fp_add_normalize_if.sv
// Handshake and operand/result bundle for the FP add normalize/round stage.
// master drives operands and out_ready; slave is the normalize stage itself.
interface fp_add_normalize_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    sign_a;
  logic                    sign_b;
  logic [EXP_W-1:0]        exponent_in;
  logic [MANT_W:0]         aligned_mantissa_a;
  logic [MANT_W:0]         aligned_mantissa_b;
  logic                    guard_in;
  logic                    round_in;
  logic                    sticky_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W:0]   result;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output in_valid, sign_a, sign_b, exponent_in,
    output aligned_mantissa_a, aligned_mantissa_b,
    output guard_in, round_in, sticky_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, sign_a, sign_b, exponent_in,
    input  aligned_mantissa_a, aligned_mantissa_b,
    input  guard_in, round_in, sticky_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_add_normalize.sv
// Add/subtract, normalize and RNE-round stage of the single-precision FP adder.
// Define FP_FAST_NORM_EN for a one-cycle LZC + barrel-shift normalize (same results).
module fp_add_normalize #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input logic               clock,
  input logic               reset,
  fp_add_normalize_if.slave bus
);
  localparam int unsigned MW = MANT_W + 1;
  localparam int unsigned DW = MW + 3;
  localparam int unsigned XW = EXP_W + 1;
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD   = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state;
  logic                  sa_q, sb_q, sr_q;
  logic [MW-1:0]         ma_q, mb_q;
  logic [2:0]            grs_q;
  logic [DW-1:0]         m_q;
  logic [XW-1:0]         ex_q;
  logic [EXP_W+MANT_W:0] result_q;
  logic                  ovf_q, unf_q;

  logic                  a_ge, l_sign, eff_sub;
  logic [DW-1:0]         lx, sx, add_m;
  logic [DW:0]           sum;
  logic [XW-1:0]         add_e;

  logic                  inc, rnd_ovf;
  logic [MW:0]           rnd;
  logic [MANT_W-1:0]     rnd_frac;
  logic [XW-1:0]         rnd_e;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

  // GRS always belong to the smaller operand; equal mantissas arrive with GRS=0.
  always_comb begin
    a_ge    = (ma_q >= mb_q);
    l_sign  = a_ge ? sa_q : sb_q;
    eff_sub = sa_q ^ sb_q;
    lx      = {(a_ge ? ma_q : mb_q), 3'b000};
    sx      = {(a_ge ? mb_q : ma_q), grs_q};
    sum     = eff_sub ? ({1'b0, lx} - {1'b0, sx}) : ({1'b0, lx} + {1'b0, sx});
    add_m   = sum[DW] ? {sum[DW:2], sum[1] | sum[0]} : sum[DW-1:0];
    add_e   = ex_q + XW'(sum[DW]);
  end

  always_comb begin
    inc      = m_q[2] & (m_q[3] | m_q[1] | m_q[0]);
    rnd      = {1'b0, m_q[DW-1:3]} + (MW+1)'(inc);
    rnd_frac = rnd[MW] ? rnd[MW-1:1] : rnd[MANT_W-1:0];
    rnd_e    = ex_q + XW'(rnd[MW]);
    rnd_ovf  = (rnd_e >= EXP_MAX);
  end

`ifdef FP_FAST_NORM_EN
  localparam int unsigned LZW = $clog2(DW);
  logic [LZW-1:0] lzc;

  always_comb begin
    lzc = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (m_q[i]) lzc = LZW'(DW - 1 - i);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sa_q  <= bus.sign_a;
            sb_q  <= bus.sign_b;
            ma_q  <= bus.aligned_mantissa_a;
            mb_q  <= bus.aligned_mantissa_b;
            grs_q <= {bus.guard_in, bus.round_in, bus.sticky_in};
            ex_q  <= {1'b0, bus.exponent_in};
            state <= S_ADD;
          end
        end
        S_ADD: begin
          sr_q <= l_sign;
          if (sum == '0) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            state    <= S_DONE;
          end else begin
            m_q   <= add_m;
            ex_q  <= add_e;
            state <= add_m[DW-1] ? S_ROUND : S_NORM;
          end
        end
        S_NORM: begin
`ifdef FP_FAST_NORM_EN
          if (XW'(lzc) >= ex_q) begin
            result_q <= {sr_q, {(EXP_W+MANT_W){1'b0}}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b1;
            state    <= S_DONE;
          end else begin
            m_q   <= m_q << lzc;
            ex_q  <= ex_q - XW'(lzc);
            state <= S_ROUND;
          end
`else
          // Flush before the shift that would take the exponent to zero.
          if (ex_q <= XW'(1)) begin
            result_q <= {sr_q, {(EXP_W+MANT_W){1'b0}}};
            ovf_q    <= 1'b0;
            unf_q    <= 1'b1;
            state    <= S_DONE;
          end else begin
            m_q  <= m_q << 1;
            ex_q <= ex_q - XW'(1);
            if (m_q[DW-2]) state <= S_ROUND;
          end
`endif
        end
        S_ROUND: begin
          if (rnd_ovf) begin
            result_q <= {sr_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          end else begin
            result_q <= {sr_q, rnd_e[EXP_W-1:0], rnd_frac};
          end
          ovf_q <= rnd_ovf;
          unf_q <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_normalize.sv
// Self-checking bench for fp_add_normalize: directed spec cases plus random
// operands checked against an exact-integer RNE reference model.
module tb_fp_add_normalize;
`ifdef FP_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_normalize_if #(.EXP_W(8), .MANT_W(23)) bus ();

  fp_add_normalize #(.EXP_W(8), .MANT_W(23)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] xp);
    compared++;
    assert (obs === xp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, xp);
    end
  endtask

  // Exact signed sum of the two extended operands, normalized and RNE-rounded
  // by plain integer arithmetic; latency from the leading-zero count.
  function automatic void ref_model(input bit sa, input bit sb, input int e,
                                    input longint ax, input longint bx,
                                    output logic [31:0] res, output logic ovf,
                                    output logic unf, output int lat);
    longint v, mag, mant, rem, half;
    int p, ee, lz, sh;
    bit sg;
    v   = (sa ? -ax : ax) + (sb ? -bx : bx);
    sg  = (v < 0);
    mag = sg ? -v : v;
    ovf = 1'b0;
    unf = 1'b0;
    if (mag == 0) begin
      res = '0;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) p = i;
    lz = (p < 26) ? 26 - p : 0;
    ee = e + p - 26;
    if (ee <= 0) begin
      res = {sg, 31'b0};
      unf = 1'b1;
      lat = FAST ? 2 : 1 + e;
      return;
    end
    if (p >= 23) begin
      sh   = p - 23;
      mant = mag >>> sh;
      rem  = mag - (mant <<< sh);
      if (sh > 0) begin
        half = longint'(1) <<< (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant++;
      end
    end else begin
      mant = mag <<< (23 - p);
    end
    if (mant == (longint'(1) <<< 24)) begin
      mant = mant >>> 1;
      ee++;
    end
    if (ee >= 255) begin
      res = {sg, 8'hFF, 23'b0};
      ovf = 1'b1;
    end else begin
      res = {sg, ee[7:0], mant[22:0]};
    end
    lat = FAST ? ((lz == 0) ? 2 : 3) : 2 + lz;
  endfunction

  task automatic drive(input bit sa, input bit sb, input logic [7:0] e,
                       input logic [23:0] ma, input logic [23:0] mb,
                       input logic g, input logic r, input logic s);
    @(negedge clk);
    bus.sign_a             = sa;
    bus.sign_b             = sb;
    bus.exponent_in        = e;
    bus.aligned_mantissa_a = ma;
    bus.aligned_mantissa_b = mb;
    bus.guard_in           = g;
    bus.round_in           = r;
    bus.sticky_in          = s;
    bus.in_valid           = 1'b1;
    check("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_op(input string tag, input bit sa, input bit sb, input logic [7:0] e,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic g, input logic r, input logic s,
                        input logic [31:0] xres, input logic xo, input logic xu, input int xlat);
    int lat;
    drive(sa, sb, e, ma, mb, g, r, s);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(xlat));
    check({tag, "_res"}, bus.result, xres);
    check({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, xo});
    check({tag, "_unf"}, {31'b0, bus.underflow}, {31'b0, xu});
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] xr;
    logic xo, xu;
    int xl;
    bus.in_valid           = 1'b0;
    bus.out_ready          = 1'b1;
    bus.sign_a             = 1'b0;
    bus.sign_b             = 1'b0;
    bus.exponent_in        = '0;
    bus.aligned_mantissa_a = '0;
    bus.aligned_mantissa_b = '0;
    bus.guard_in           = 1'b0;
    bus.round_in           = 1'b0;
    bus.sticky_in          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'h0);
    check("rst_ovf", {31'b0, bus.overflow}, 32'd0);
    check("rst_unf", {31'b0, bus.underflow}, 32'd0);
    rst = 1'b0;

    run_op("one_plus_one", 0, 0, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'h40000000, 0, 0, 2);
    run_op("one_minus_one", 0, 1, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'h00000000, 0, 0, 1);
    run_op("p15_minus_p125", 0, 1, 8'd127, 24'hC00000, 24'hA00000, 0, 0, 0, 32'h3E800000, 0, 0,
           FAST ? 3 : 4);
    run_op("rne_tie_odd", 0, 0, 8'd127, 24'h800001, 24'h000000, 1, 0, 0, 32'h3F800002, 0, 0, 2);
    run_op("rne_tie_even", 0, 0, 8'd127, 24'h800000, 24'h000000, 1, 0, 0, 32'h3F800000, 0, 0, 2);
    run_op("underflow_neg", 1, 0, 8'd1, 24'hC00000, 24'hA00000, 0, 0, 0, 32'h80000000, 0, 1, 2);

    // Overflow result held under back-pressure, flags kept after the handshake.
    bus.out_ready = 1'b0;
    drive(0, 0, 8'd254, 24'h800000, 24'h800000, 0, 0, 0);
    wait_valid(lat);
    check("ovf_lat", 32'(lat), 32'd2);
    check("ovf_res", bus.result, 32'h7F800000);
    check("ovf_flag", {31'b0, bus.overflow}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_res", bus.result, 32'h7F800000);
      check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_hs_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("post_hs_res", bus.result, 32'h7F800000);
    check("post_hs_ovf", {31'b0, bus.overflow}, 32'd1);

    // Reset while normalizing drops the operation.
    drive(0, 1, 8'd127, 24'hC00000, 24'hA00000, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_norm_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_norm_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_norm_res", bus.result, 32'h0);
    check("rst_norm_ovf", {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;
    run_op("after_rst", 0, 0, 8'd127, 24'h800000, 24'h800000, 0, 0, 0, 32'h40000000, 0, 0, 2);

    for (int n = 0; n < 80; n++) begin
      logic [23:0] m1, m2, msh;
      logic [49:0] w;
      logic g, r, s;
      bit sa, sb, swap;
      int d, e;
      longint ax, bx;
      e  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 254));
      m1 = {1'b1, 23'($urandom)};
      m2 = {1'b1, 23'($urandom)};
      d  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 26));
      if ($urandom_range(0, 7) == 0) begin
        d  = 0;
        m2 = m1;
      end
      w    = {m2, 26'b0} >> d;
      msh  = w[49:26];
      g    = w[25];
      r    = w[24];
      s    = |w[23:0];
      sa   = 1'($urandom);
      sb   = 1'($urandom);
      swap = 1'($urandom);
      if (swap) begin
        ax = longint'({msh, g, r, s});
        bx = longint'({m1, 3'b000});
        ref_model(sa, sb, e, ax, bx, xr, xo, xu, xl);
        run_op("rand", sa, sb, 8'(e), msh, m1, g, r, s, xr, xo, xu, xl);
      end else begin
        ax = longint'({m1, 3'b000});
        bx = longint'({msh, g, r, s});
        ref_model(sa, sb, e, ax, bx, xr, xo, xu, xl);
        run_op("rand", sa, sb, 8'(e), m1, msh, g, r, s, xr, xo, xu, xl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
